// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Types and constants shared by the decode/execute pipeline register and
//   the ControlUnit: the packed control bundle, the bubble (NOP) value and
//   the ALU / immediate-extension encodings.
package cpu_pkg;

    // Field order matches the ControlUnit output bundle, MSB first.
    typedef struct packed {
        logic       wmem;
        logic       rmem;
        logic       wreg;
        logic       wpc;
        logic       cond_en;
        logic [1:0] jmp_f;
        logic [2:0] alu_ins;
        logic [1:0] extnd_sel;
    } ctrl_t;

    // An all-zero bundle writes nothing, reads nothing and never branches.
    localparam ctrl_t CTRL_NOP = '0;

    localparam logic [2:0] ALU_STR  = 3'b111;
    localparam logic [2:0] ALU_MOVI = 3'b101;
    localparam logic [2:0] ALU_DDR  = 3'b100;
    localparam logic [2:0] ALU_JMP  = 3'b000;

    localparam logic [1:0] EXT_ZERO = 2'b00;
    localparam logic [1:0] EXT_SIGN = 2'b01;
    localparam logic [1:0] EXT_HIGH = 2'b10;

    // True when the bundle has no architectural side effect.
    function automatic logic ctrl_is_inert(input ctrl_t c);
        return !(c.wmem || c.rmem || c.wreg || c.wpc);
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect
//   Purely combinational load-use hazard detector. Flags when the instruction
//   in EX is a valid load that writes a register which the valid instruction
//   in ID actually reads. Register 0 is compared like any other register.
//   Ports:
//     ex_valid_i, ex_rmem_i, ex_wreg_i, ex_rd_i : state of the EX slot
//     id_valid_i, id_rs*_i, id_use*_i          : sources of the ID instruction
//     haz_o                                      : hazard present
module load_use_detect #(
    parameter int REG_AW = 4
) (
    input  logic              ex_valid_i,
    input  logic              ex_rmem_i,
    input  logic              ex_wreg_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic              id_valid_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic              id_use1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use2_i,
    output logic              haz_o
);

    logic ex_is_load;
    logic src_match;

    always_comb begin
        ex_is_load = ex_valid_i & ex_rmem_i & ex_wreg_i;
        src_match  = (id_use1_i & (id_rs1_i == ex_rd_i)) |
                     (id_use2_i & (id_rs2_i == ex_rd_i));
        haz_o      = ex_is_load & id_valid_i & src_match;
    end

endmodule

// File: rtl/idex_stage.sv
// idex_stage
//   Decode->Execute pipeline register with load-use interlock.
//   Ports:
//     clk, rst          : clock, synchronous active-high reset
//     hold_i            : freeze every flop (memory busy)
//     flush_i           : kill the instruction entering EX (branch taken)
//     id_*_i            : decoded instruction from ID
//     stall_if_o        : combinational load-use stall request to PC and IF/ID
//     ex_*_o            : registered instruction in EX
//     bubble_cnt_o      : saturating count of injected bubbles
module idex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  ctrl_t             id_ctrl_i,
    input  logic [DATA_W-1:0] id_rd1_i,
    input  logic [DATA_W-1:0] id_rd2_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [DATA_W-1:0] id_pc_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic              id_use1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              id_use2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    output logic              stall_if_o,
    output logic              ex_valid_o,
    output ctrl_t             ex_ctrl_o,
    output logic [DATA_W-1:0] ex_rd1_o,
    output logic [DATA_W-1:0] ex_rd2_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [DATA_W-1:0] ex_pc_o,
    output logic [REG_AW-1:0] ex_rs1_o,
    output logic [REG_AW-1:0] ex_rs2_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              valid_q, valid_d;
    ctrl_t             ctrl_q, ctrl_d;
    logic [DATA_W-1:0] rd1_q, rd1_d, rd2_q, rd2_d, imm_q, imm_d, pc_q, pc_d;
    logic [REG_AW-1:0] rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              haz;

    load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
        .ex_valid_i (valid_q),
        .ex_rmem_i  (ctrl_q.rmem),
        .ex_wreg_i  (ctrl_q.wreg),
        .ex_rd_i    (rd_q),
        .id_valid_i (id_valid_i),
        .id_rs1_i   (id_rs1_i),
        .id_use1_i  (id_use1_i),
        .id_rs2_i   (id_rs2_i),
        .id_use2_i  (id_use2_i),
        .haz_o      (haz)
    );

    // A flushed ID instruction is dead anyway, so it never needs to wait.
    assign stall_if_o = haz & ~flush_i;

    // Priority: hold freezes everything, then flush/hazard bubbles, then load.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        imm_d   = imm_q;
        pc_d    = pc_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        if (hold_i) begin
            // keep current state
        end else if (flush_i || haz) begin
            valid_d = 1'b0;
            ctrl_d  = CTRL_NOP;
            rd1_d   = '0;
            rd2_d   = '0;
            imm_d   = '0;
            pc_d    = '0;
            rs1_d   = '0;
            rs2_d   = '0;
            rd_d    = '0;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            valid_d = id_valid_i;
            // An empty ID slot must not carry side effects into EX.
            ctrl_d  = id_valid_i ? id_ctrl_i : CTRL_NOP;
            rd1_d   = id_rd1_i;
            rd2_d   = id_rd2_i;
            imm_d   = id_imm_i;
            pc_d    = id_pc_i;
            rs1_d   = id_rs1_i;
            rs2_d   = id_rs2_i;
            rd_d    = id_rd_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_NOP;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            pc_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            pc_q    <= pc_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid_o   = valid_q;
    assign ex_ctrl_o    = ctrl_q;
    assign ex_rd1_o     = rd1_q;
    assign ex_rd2_o     = rd2_q;
    assign ex_imm_o     = imm_q;
    assign ex_pc_o      = pc_q;
    assign ex_rs1_o     = rs1_q;
    assign ex_rs2_o     = rs2_q;
    assign ex_rd_o      = rd_q;
    assign bubble_cnt_o = cnt_q;

endmodule

// File: tb/tb_idex_stage.sv
// tb_idex_stage
//   Directed bench for idex_stage: reset, pass-through, load-use interlock,
//   flush vs hazard, hold priority, back-to-back loads, reset mid-stall and
//   bubble counter saturation.
module tb_idex_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst, hold_i, flush_i, id_valid_i;
    ctrl_t       id_ctrl_i;
    logic [31:0] id_rd1_i, id_rd2_i, id_imm_i, id_pc_i;
    logic [3:0]  id_rs1_i, id_rs2_i, id_rd_i;
    logic        id_use1_i, id_use2_i;
    logic        stall_if_o, ex_valid_o;
    ctrl_t       ex_ctrl_o;
    logic [31:0] ex_rd1_o, ex_rd2_o, ex_imm_o, ex_pc_o;
    logic [3:0]  ex_rs1_o, ex_rs2_o, ex_rd_o;
    logic [15:0] bubble_cnt_o;

    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_cnt = 16'd0;

    ctrl_t c_load, c_add, c_movi;

    idex_stage #(.DATA_W(32), .REG_AW(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .hold_i(hold_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_ctrl_i(id_ctrl_i),
        .id_rd1_i(id_rd1_i), .id_rd2_i(id_rd2_i), .id_imm_i(id_imm_i), .id_pc_i(id_pc_i),
        .id_rs1_i(id_rs1_i), .id_use1_i(id_use1_i), .id_rs2_i(id_rs2_i), .id_use2_i(id_use2_i),
        .id_rd_i(id_rd_i), .stall_if_o(stall_if_o), .ex_valid_o(ex_valid_o), .ex_ctrl_o(ex_ctrl_o),
        .ex_rd1_o(ex_rd1_o), .ex_rd2_o(ex_rd2_o), .ex_imm_o(ex_imm_o), .ex_pc_o(ex_pc_o),
        .ex_rs1_o(ex_rs1_o), .ex_rs2_o(ex_rs2_o), .ex_rd_o(ex_rd_o), .bubble_cnt_o(bubble_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input ctrl_t c, input logic [31:0] imm,
                          input logic [3:0] rs1, input logic u1,
                          input logic [3:0] rs2, input logic u2, input logic [3:0] rd);
        id_valid_i = v;
        id_ctrl_i  = c;
        id_imm_i   = imm;
        id_rd1_i   = imm ^ 32'h1111_0000;
        id_rd2_i   = imm ^ 32'h0000_2222;
        id_pc_i    = {imm[29:0], 2'b00};
        id_rs1_i   = rs1;
        id_use1_i  = u1;
        id_rs2_i   = rs2;
        id_use2_i  = u2;
        id_rd_i    = rd;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; hold_i = 1'b0; flush_i = 1'b0;
        set_id(1'b1, ctrl_t'($urandom), $urandom, 4'($urandom), 1'b1, 4'($urandom), 1'b1, 4'($urandom));
        tick();
        tick();
        total++; if (ex_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", ex_valid_o); end
        total++; if (ex_ctrl_o !== CTRL_NOP) begin bad++; $display("[TB] FAIL reset_ctrl got=%h exp=0", ex_ctrl_o); end
        total++; if (bubble_cnt_o !== 16'd0) begin bad++; $display("[TB] FAIL reset_cnt got=%h exp=0", bubble_cnt_o); end
        total++; if (stall_if_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_stall got=%b exp=0", stall_if_o); end
        total++; if (ex_imm_o !== 32'd0 || ex_rd_o !== 4'd0) begin bad++; $display("[TB] FAIL reset_fields got imm=%h rd=%h exp=0", ex_imm_o, ex_rd_o); end
        rst = 1'b0;
        exp_cnt = 16'd0;
    endtask

    task automatic test_pass_through();
        set_id(1'b1, c_movi, 32'h2A, 4'd1, 1'b0, 4'd2, 1'b0, 4'd7);
        tick();
        total++; if (ex_ctrl_o.alu_ins !== ALU_MOVI) begin bad++; $display("[TB] FAIL pass_alu got=%b exp=101", ex_ctrl_o.alu_ins); end
        total++; if (ex_imm_o !== 32'h2A) begin bad++; $display("[TB] FAIL pass_imm got=%h exp=2a", ex_imm_o); end
        total++; if (ex_valid_o !== 1'b1 || ex_rd_o !== 4'd7) begin bad++; $display("[TB] FAIL pass_valid_rd got=%b/%h exp=1/7", ex_valid_o, ex_rd_o); end
        total++; if (ex_rd1_o !== 32'h1111_002A || ex_pc_o !== 32'hA8) begin bad++; $display("[TB] FAIL pass_ops got rd1=%h pc=%h exp=1111002a/a8", ex_rd1_o, ex_pc_o); end
        // an empty ID slot still loads data but carries a NOP control bundle
        set_id(1'b0, c_add, 32'h55, 4'd1, 1'b1, 4'd2, 1'b1, 4'd9);
        tick();
        total++; if (ex_valid_o !== 1'b0 || ex_ctrl_o !== CTRL_NOP) begin bad++; $display("[TB] FAIL invalid_nop got=%b/%h exp=0/0", ex_valid_o, ex_ctrl_o); end
        total++; if (ex_imm_o !== 32'h55) begin bad++; $display("[TB] FAIL invalid_imm got=%h exp=55", ex_imm_o); end
    endtask

    task automatic test_load_use();
        set_id(1'b1, c_load, 32'h10, 4'd0, 1'b1, 4'd0, 1'b0, 4'd3);
        tick();
        set_id(1'b1, c_add, 32'h20, 4'd3, 1'b1, 4'd4, 1'b1, 4'd6);
        total++; if (stall_if_o !== 1'b1) begin bad++; $display("[TB] FAIL lu_stall got=%b exp=1", stall_if_o); end
        tick();
        exp_cnt++;
        total++; if (ex_ctrl_o !== CTRL_NOP || ex_valid_o !== 1'b0) begin bad++; $display("[TB] FAIL lu_bubble got=%h/%b exp=0/0", ex_ctrl_o, ex_valid_o); end
        total++; if (bubble_cnt_o !== exp_cnt) begin bad++; $display("[TB] FAIL lu_cnt got=%h exp=%h", bubble_cnt_o, exp_cnt); end
        total++; if (stall_if_o !== 1'b0) begin bad++; $display("[TB] FAIL lu_stall_drop got=%b exp=0", stall_if_o); end
        tick();
        total++; if (ex_ctrl_o !== c_add || ex_valid_o !== 1'b1 || ex_imm_o !== 32'h20) begin bad++; $display("[TB] FAIL lu_reissue got=%h/%b/%h exp=%h/1/20", ex_ctrl_o, ex_valid_o, ex_imm_o, c_add); end
        // rs2 match triggers too; an unused matching source does not
        set_id(1'b1, c_load, 32'h30, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        tick();
        set_id(1'b1, c_add, 32'h40, 4'd5, 1'b1, 4'd0, 1'b1, 4'd1);
        total++; if (stall_if_o !== 1'b1) begin bad++; $display("[TB] FAIL lu_r0_rs2 got=%b exp=1", stall_if_o); end
        set_id(1'b1, c_add, 32'h40, 4'd0, 1'b0, 4'd5, 1'b1, 4'd1);
        total++; if (stall_if_o !== 1'b0) begin bad++; $display("[TB] FAIL lu_unused got=%b exp=0", stall_if_o); end
        tick();
    endtask

    task automatic test_flush_vs_hazard();
        set_id(1'b1, c_load, 32'h50, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3);
        tick();
        set_id(1'b1, c_add, 32'h60, 4'd3, 1'b1, 4'd0, 1'b0, 4'd6);
        flush_i = 1'b1;
        #1;
        total++; if (stall_if_o !== 1'b0) begin bad++; $display("[TB] FAIL flush_stall got=%b exp=0", stall_if_o); end
        tick();
        exp_cnt++;
        flush_i = 1'b0;
        total++; if (ex_valid_o !== 1'b0 || ex_ctrl_o !== CTRL_NOP || ex_imm_o !== 32'd0) begin bad++; $display("[TB] FAIL flush_bubble got=%b/%h/%h exp=0/0/0", ex_valid_o, ex_ctrl_o, ex_imm_o); end
        total++; if (bubble_cnt_o !== exp_cnt) begin bad++; $display("[TB] FAIL flush_cnt got=%h exp=%h", bubble_cnt_o, exp_cnt); end
    endtask

    task automatic test_hold();
        set_id(1'b1, c_load, 32'h70, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3);
        tick();
        set_id(1'b1, c_add, 32'h80, 4'd3, 1'b1, 4'd3, 1'b1, 4'd6);
        hold_i = 1'b1;
        flush_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (ex_ctrl_o !== c_load || ex_valid_o !== 1'b1 || ex_imm_o !== 32'h70 || ex_rd_o !== 4'd3) begin
                bad++; $display("[TB] FAIL hold_state cyc=%0d got=%h/%b/%h/%h exp=%h/1/70/3", i, ex_ctrl_o, ex_valid_o, ex_imm_o, ex_rd_o, c_load);
            end
            total++; if (bubble_cnt_o !== exp_cnt) begin bad++; $display("[TB] FAIL hold_cnt cyc=%0d got=%h exp=%h", i, bubble_cnt_o, exp_cnt); end
        end
        hold_i = 1'b0;
        flush_i = 1'b0;
        set_id(1'b0, CTRL_NOP, 32'h0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        tick();
    endtask

    task automatic test_back_to_back();
        set_id(1'b1, c_load, 32'h90, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3);
        tick();
        set_id(1'b1, c_load, 32'hA0, 4'd3, 1'b1, 4'd0, 1'b0, 4'd5);
        total++; if (stall_if_o !== 1'b1) begin bad++; $display("[TB] FAIL b2b_stall1 got=%b exp=1", stall_if_o); end
        tick();
        exp_cnt++;
        total++; if (stall_if_o !== 1'b0) begin bad++; $display("[TB] FAIL b2b_one_bubble got=%b exp=0", stall_if_o); end
        tick();
        total++; if (ex_ctrl_o !== c_load || ex_rd_o !== 4'd5) begin bad++; $display("[TB] FAIL b2b_second got=%h/%h exp=%h/5", ex_ctrl_o, ex_rd_o, c_load); end
        set_id(1'b1, c_add, 32'hB0, 4'd1, 1'b1, 4'd5, 1'b1, 4'd2);
        total++; if (stall_if_o !== 1'b1) begin bad++; $display("[TB] FAIL b2b_stall2 got=%b exp=1", stall_if_o); end
        tick();
        exp_cnt++;
        total++; if (bubble_cnt_o !== exp_cnt) begin bad++; $display("[TB] FAIL b2b_cnt got=%h exp=%h", bubble_cnt_o, exp_cnt); end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        set_id(1'b1, c_load, 32'hC0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3);
        tick();
        set_id(1'b1, c_add, 32'hD0, 4'd3, 1'b1, 4'd0, 1'b0, 4'd6);
        total++; if (stall_if_o !== 1'b1) begin bad++; $display("[TB] FAIL rms_pre got=%b exp=1", stall_if_o); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 16'd0;
        total++; if (ex_valid_o !== 1'b0 || stall_if_o !== 1'b0 || bubble_cnt_o !== 16'd0) begin
            bad++; $display("[TB] FAIL rms_after got=%b/%b/%h exp=0/0/0", ex_valid_o, stall_if_o, bubble_cnt_o);
        end
    endtask

    task automatic test_saturation();
        set_id(1'b1, c_add, 32'hE0, 4'd1, 1'b1, 4'd2, 1'b1, 4'd4);
        flush_i = 1'b1;
        while (exp_cnt != 16'hFFFE) begin
            tick();
            exp_cnt++;
        end
        total++; if (bubble_cnt_o !== 16'hFFFE) begin bad++; $display("[TB] FAIL sat_preload got=%h exp=fffe", bubble_cnt_o); end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bubble_cnt_o !== 16'hFFFF) begin bad++; $display("[TB] FAIL sat_hold cyc=%0d got=%h exp=ffff", i, bubble_cnt_o); end
        end
        flush_i = 1'b0;
    endtask

    initial begin
        c_load = '{wmem:1'b0, rmem:1'b1, wreg:1'b1, wpc:1'b0, cond_en:1'b0, jmp_f:2'b00, alu_ins:ALU_DDR, extnd_sel:EXT_SIGN};
        c_add  = '{wmem:1'b0, rmem:1'b0, wreg:1'b1, wpc:1'b0, cond_en:1'b1, jmp_f:2'b01, alu_ins:3'b010, extnd_sel:EXT_ZERO};
        c_movi = '{wmem:1'b0, rmem:1'b0, wreg:1'b1, wpc:1'b0, cond_en:1'b0, jmp_f:2'b00, alu_ins:ALU_MOVI, extnd_sel:EXT_HIGH};
        test_reset();
        test_pass_through();
        test_load_use();
        test_flush_vs_hazard();
        test_hold();
        test_back_to_back();
        test_reset_mid_stall();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
